// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and widths for the unified memory port controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WDATA_W = 8;
  localparam int unsigned STAT_W  = 16;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Request as latched at acceptance; addr/wdata drive the memory bus directly.
  typedef struct packed {
    op_e                op;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] wdata;
  } mem_req_t;

  // Fetch and load both read a word through the bus.
  function automatic logic is_read(op_e op);
    return (op == OP_FETCH) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/mem_stat_counter.sv
// 16-bit saturating event counter with synchronous clear.
module mem_stat_counter
  import mem_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  // Count events, sticking at all-ones.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + STAT_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the unified instruction/data memory port.
// Sequences fetch/load/store requests onto a single-port memory bus and
// captures read data into IR or MDR. Optional access statistics are built
// when MEM_ACCESS_STATS_EN is defined.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WDATA_W-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [DATA_W-1:0]  instr_reg,
  output logic [DATA_W-1:0]  mdr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STAT_W-1:0]  stat_reads,
  output logic [STAT_W-1:0]  stat_writes
);

  state_e   state;
  mem_req_t req_q;
  logic     we_q;
  op_e      in_op;

  assign in_op = op_e'(req_op);

  // Bus address and write data come straight from the latched request.
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // A store caught by reset mid-access must not reach memory.
  assign mem_we = we_q & ~reset;

  // Request sequencing: IDLE -> ACCESS -> RESP, reserved op skips ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      we_q      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      instr_reg <= '0;
      mdr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q     <= '{op: in_op, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b0;
            if (in_op == OP_RSVD) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state <= ST_ACCESS;
              we_q  <= (in_op == OP_STORE);
            end
          end
        end
        ST_ACCESS: begin
          state     <= ST_RESP;
          we_q      <= 1'b0;
          rsp_valid <= 1'b1;
          // Memory ignores addr[0]; only an odd fetch address is flagged.
          rsp_err   <= (req_q.op == OP_FETCH) && req_q.addr[0];
          case (req_q.op)
            OP_FETCH: begin
              instr_reg <= mem_rdata;
              rsp_data  <= mem_rdata;
            end
            OP_LOAD: begin
              mdr      <= mem_rdata;
              rsp_data <= mem_rdata;
            end
            default: begin
              rsp_data <= '0;
            end
          endcase
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          we_q      <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic access_rd;
  logic access_wr;

  // One count per access cycle, split by direction.
  assign access_rd = (state == ST_ACCESS) && is_read(req_q.op);
  assign access_wr = (state == ST_ACCESS) && (req_q.op == OP_STORE);

  mem_stat_counter u_stat_reads (
    .clock (clock),
    .clear (reset),
    .inc   (access_rd),
    .count (stat_reads)
  );

  mem_stat_counter u_stat_writes (
    .clock (clock),
    .clear (reset),
    .inc   (access_wr),
    .count (stat_writes)
  );
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a word-array memory model.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [7:0]   req_addr;
  logic [7:0]   req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [15:0]  rsp_data;
  logic         rsp_err;
  logic [15:0]  instr_reg;
  logic [15:0]  mdr;
  logic [7:0]   mem_addr;
  logic         mem_we;
  logic [7:0]   mem_wdata;
  logic [15:0]  mem_rdata;
  logic [15:0]  stat_reads;
  logic [15:0]  stat_writes;

  mem_access_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .instr_reg   (instr_reg),
    .mdr         (mdr),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
  );

  always #5 clock = ~clock;

  // Physical memory: 128 words, byte address bit 0 ignored, writes zero-padded.
  logic [15:0] mem [0:127];
  assign mem_rdata = mem[mem_addr[7:1]];
  always @(posedge clock) if (mem_we) mem[mem_addr[7:1]] <= {8'h00, mem_wdata};

  // Reference model state.
  logic [15:0] ref_mem [0:127];
  logic [15:0] ref_ir;
  logic [15:0] ref_mdr;
  int          exp_reads;
  int          exp_writes;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [15:0] ir;
    logic [15:0] mdr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  int         we_cnt    = 0;
  logic [7:0] exp_waddr;
  logic [7:0] exp_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare each accepted response and every memory write.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        check("instr_reg", 32'(instr_reg), 32'(mon_e.ir));
        check("mdr", 32'(mdr), 32'(mon_e.mdr));
      end
    end
    if (mem_we) begin
      we_cnt++;
      check("we_addr", 32'(mem_addr), 32'(exp_waddr));
      check("we_wdata", 32'(mem_wdata), 32'(exp_wdata));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'(1));
  endtask

  // Issue one request, model its effect, then check latency and hold behaviour.
  task automatic do_req(input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input int hold);
    exp_t e;
    int   n;
    int   exp_lat;
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    exp_waddr = addr;
    exp_wdata = wdata;
    we_cnt    = 0;
    e.data = 16'h0000;
    e.err  = 1'b0;
    case (op)
      2'b00: begin
        e.data = ref_mem[addr[7:1]];
        e.err  = addr[0];
        ref_ir = e.data;
        exp_reads++;
      end
      2'b01: begin
        e.data  = ref_mem[addr[7:1]];
        ref_mdr = e.data;
        exp_reads++;
      end
      2'b10: begin
        ref_mem[addr[7:1]] = {8'h00, wdata};
        exp_writes++;
      end
      default: e.err = 1'b1;
    endcase
    e.ir  = ref_ir;
    e.mdr = ref_mdr;
    exp_q.push_back(e);
    exp_lat = (op == 2'b11) ? 1 : 2;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_addr  = 8'($urandom);
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_req_ready", 32'(req_ready), 32'(0));
      check("hold_data", 32'(rsp_data), 32'(e.data));
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("back_idle", 32'(req_ready), 32'(1));
    check("rsp_released", 32'(rsp_valid), 32'(0));
    check("we_count", 32'(we_cnt), 32'((op == 2'b10) ? 1 : 0));
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_instr_reg", 32'(instr_reg), 32'(0));
    check("rst_mdr", 32'(mdr), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst_stat_reads", 32'(stat_reads), 32'(0));
    check("rst_stat_writes", 32'(stat_writes), 32'(0));
  endtask

  // Store interrupted by reset during its access cycle.
  task automatic reset_during_store();
    wait_ready();
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 8'h90;
    req_wdata = 8'hA5;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("we_under_reset", 32'(mem_we), 32'(0));
    @(posedge clock); #1;
    check_reset_outputs();
    reset = 1'b0;
    ref_ir     = 16'h0000;
    ref_mdr    = 16'h0000;
    exp_reads  = 0;
    exp_writes = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'($urandom);
    ref_mem[1]    = 16'h8907;
    ref_mem[8'h48] = 16'hBEEF;
    for (int i = 0; i < 128; i++) mem[i] <= ref_mem[i];
    ref_ir     = 16'h0000;
    ref_mdr    = 16'h0000;
    exp_reads  = 0;
    exp_writes = 0;
    exp_waddr  = 8'h00;
    exp_wdata  = 8'h00;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 8'h00;
    req_wdata  = 8'h00;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    do_req(2'b00, 8'h02, 8'h00, 0);
    do_req(2'b10, 8'h80, 8'h83, 0);
    do_req(2'b01, 8'h80, 8'h00, 0);
    do_req(2'b00, 8'h03, 8'h00, 0);
    do_req(2'b11, 8'h55, 8'h12, 0);
    do_req(2'b01, 8'h02, 8'h00, 5);
    reset_during_store();
    do_req(2'b00, 8'h90, 8'h00, 1);

    for (int k = 0; k < 60; k++) begin
      do_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'(0));
`ifdef MEM_ACCESS_STATS_EN
    check("stat_reads", 32'(stat_reads), 32'(exp_reads));
    check("stat_writes", 32'(stat_writes), 32'(exp_writes));
`else
    check("stat_reads", 32'(stat_reads), 32'(0));
    check("stat_writes", 32'(stat_writes), 32'(0));
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
